vortex_axi_mem_slave: RTL and testbench
=======================================

# vortex_axi_mem_slave

AXI4 memory slave that terminates the Vortex `m_axi_*` master port inside the bridge and replaces the fake memory controller. It accepts single- and multi-beat INCR/FIXED bursts, stores data in an on-chip byte-enabled SRAM, and returns AXI responses. It runs entirely in the Vortex `ap_clk` domain, with the top level driving `clk` from `ap_clk`.

## Interface
- `ID_WIDTH`, 32, AXI ID width
- `ADDR_WIDTH`, 64, AXI address width
- `DATA_WIDTH`, 512, AXI data width (power of two, ≥ 64)
- `MEM_DEPTH_LOG2`, 10, log2 of the number of DATA_WIDTH words
- `clk`  in  1  Vortex clock. One clock domain only.
- `rst_n`  in  1  reset: asynchronous assert, active-low
- AW channel:
  - `s_axi_awvalid` in 1
  - `s_axi_awready` out 1
  - `s_axi_awaddr` in ADDR_WIDTH
  - `s_axi_awid` in ID_WIDTH
  - `s_axi_awlen` in 8
  - `s_axi_awsize` in 3
  - `s_axi_awburst` in 2
- W channel:
  - `s_axi_wvalid` in 1
  - `s_axi_wready` out 1
  - `s_axi_wdata` in DATA_WIDTH
  - `s_axi_wstrb` in DATA_WIDTH/8
  - `s_axi_wlast` in 1
- B channel:
  - `s_axi_bvalid` out 1
  - `s_axi_bready` in 1
  - `s_axi_bid` out ID_WIDTH
  - `s_axi_bresp` out 2
- AR channel:
  - `s_axi_arvalid` in 1
  - `s_axi_arready` out 1
  - `s_axi_araddr` in ADDR_WIDTH
  - `s_axi_arid` in ID_WIDTH
  - `s_axi_arlen` in 8
  - `s_axi_arsize` in 3
  - `s_axi_arburst` in 2
- R channel:
  - `s_axi_rvalid` out 1
  - `s_axi_rready` in 1
  - `s_axi_rdata` out DATA_WIDTH
  - `s_axi_rlast` out 1
  - `s_axi_rid` out ID_WIDTH
  - `s_axi_rresp` out 2

## Operation
- Single FSM with states IDLE, WR_DATA, WR_RESP, RD_FETCH and RD_DATA. Only one burst is in flight at a time.
- **IDLE arbitration**
  - `awready` and `arready` are combinational grants, and at most one is high per cycle.
  - If both valids are high, the channel not granted last wins. The `last_grant` flop resets to "read", so write wins first.
- **Address decode**
  - `LSB = log2(DATA_WIDTH/8)`.
  - Word index = `addr[LSB +: MEM_DEPTH_LOG2]`.
  - Any set bit above `LSB+MEM_DEPTH_LOG2` gives DECERR.
  - `awsize`/`arsize` are ignored; every beat is a full-width word.
- **Burst type**
  - INCR: the index increments per beat and wraps modulo depth.
  - FIXED: the index holds.
  - WRAP or reserved: SLVERR.
- **Write path**
  - AW handshake captures id, index, len, burst and error, then moves to WR_DATA.
  - In WR_DATA, `wready`=1. Each beat handshake writes the strobed bytes, unless an error is latched.
  - The beat counter reaches `awlen` → WR_RESP. `wlast` is not used to terminate.
  - If `wlast` mismatches the counter on any beat, SLVERR is latched.
- **Write response:** in WR_RESP, `bvalid`=1 and is held until `bready`, then the FSM returns to IDLE. DECERR takes priority over SLVERR, which takes priority over OKAY.
- **Read path**
  - AR handshake → RD_FETCH, which issues the SRAM read → RD_DATA.
  - In RD_DATA, `rvalid`=1 and rdata is held until `rready`.
  - On a handshake, a non-final beat goes to RD_FETCH; the final beat (`rlast`=1) goes to IDLE.
  - On error, rdata is 0 and the error response is returned on every beat. The burst length is still honoured.
- SRAM contents are not reset.

## Timing
- **Reset values**
  - All valid and ready outputs are 0.
  - `bid`, `rid`, `rdata`, `bresp`, `rresp` and `rlast` are 0.
  - The FSM is in IDLE.
- **Reset mid-burst:** the burst is abandoned with no response, and no further SRAM write occurs after reset asserts.
- **Write latency**
  - AW handshake at cycle N → `wready` high at N+1.
  - Last W handshake at M → `bvalid` at M+1.
  - The first IDLE grant after `bready` is at the cycle after the B handshake.
- **Read latency**
  - AR handshake at N → first `rvalid` at N+2.
  - Read throughput is 1 beat per 2 cycles with back-to-back `rready`.
- `awlen`=255 INCR starting at index depth−1: beat 1 goes to index 0.
- A read issued immediately after a write returns the newly written data; there is no hazard, since the bursts are serialized.

## Structure
- Package `vortex_axi_mem_pkg` holds:
  - burst encodings (FIXED=0, INCR=1, WRAP=2)
  - resp encodings (OKAY=0, SLVERR=2, DECERR=3)
  - FSM state enum
  - `LSB` computation function
- Sub-module `vortex_axi_mem_sram`: single-port synchronous RAM with per-byte write enable and 1-cycle read latency.

## Test plan
- INCR write: `awaddr`=0x40, `awlen`=3, 4 beats with data k, full strobes. Then INCR read of the same region → B OKAY with matching id; 4 R beats return k in order, `rlast` on beat 4, first `rvalid` 2 cycles after AR.
- Partial strobe: write 0xFF..FF with `wstrb`=all ones, then 0 with `wstrb`=0x1 → read returns low byte 0x00 and all other bytes 0xFF.
- Simultaneous `awvalid`/`arvalid` from reset → AW granted first; the next simultaneous request grants AR.
- `awaddr` with bit `LSB+MEM_DEPTH_LOG2` set → SRAM unchanged, `bresp`=DECERR. Read of the same address → zero data, `rresp`=DECERR on all `arlen`+1 beats.
- `arburst`=WRAP → SLVERR on every beat. Write with an early `wlast` on beat 1 of `awlen`=3 → 4 beats accepted, `bresp`=SLVERR.
- Assert `rst_n` low during beat 2 of a 4-beat write → no `bvalid`, beats 3–4 not written, all outputs 0 until release.

Source files
------------

// File: rtl/vortex_axi_mem_pkg.sv
// rtl/vortex_axi_mem_pkg.sv - shared encodings and helpers for the Vortex AXI memory slave
//
// Purpose: AXI burst and response encodings, the slave FSM state type and
//          the helper that turns the data width into the byte-offset width.
// Ports:   none (package).
package vortex_axi_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_DATA  = 3'd1,
    ST_WR_RESP  = 3'd2,
    ST_RD_FETCH = 3'd3,
    ST_RD_DATA  = 3'd4
  } state_t;

  // Number of address bits that select a byte inside one data word.
  function automatic int axi_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/vortex_axi_mem_sram.sv
// rtl/vortex_axi_mem_sram.sv - single-port byte-enabled SRAM with 1-cycle read latency
//
// Purpose: word-wide storage for the AXI memory slave. Contents are not reset.
// Ports:
//   clk      in   clock
//   i_re     in   read enable; o_rdata updates on the next edge
//   i_we     in   per-byte write enables
//   i_addr   in   word index
//   i_wdata  in   write data
//   o_rdata  out  registered read data (holds until the next read)
module vortex_axi_mem_sram #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_BITS  = 10
) (
  input  logic                    clk,
  input  logic                    i_re,
  input  logic [DATA_WIDTH/8-1:0] i_we,
  input  logic [ADDR_BITS-1:0]    i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (i_we[b]) begin
        r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    if (i_re) begin
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/vortex_axi_mem_slave.sv
// rtl/vortex_axi_mem_slave.sv - AXI4 memory slave terminating the Vortex m_axi port
//
// Purpose: accepts one INCR/FIXED burst at a time and serves it from an
//          on-chip byte-enabled SRAM, returning AXI responses.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   s_axi_aw*         write address channel (awsize ignored, full-width beats)
//   s_axi_w*          write data channel
//   s_axi_b*          write response channel
//   s_axi_ar*         read address channel (arsize ignored, full-width beats)
//   s_axi_r*          read data channel
module vortex_axi_mem_slave
  import vortex_axi_mem_pkg::*;
#(
  parameter int ID_WIDTH       = 32,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 512,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                    s_axi_rlast,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [1:0]              s_axi_rresp
);

  localparam int LSB = axi_lsb(DATA_WIDTH);

  state_t                    r_state, w_next_state;
  logic                      r_last_grant_rd;
  logic [ID_WIDTH-1:0]       r_id;
  logic [MEM_DEPTH_LOG2-1:0] r_idx;
  logic [7:0]                r_len;
  logic [7:0]                r_beat;
  logic                      r_fixed;
  logic [1:0]                r_resp;

  logic                      w_grant_wr, w_grant_rd;
  logic                      w_aw_hs, w_ar_hs, w_w_hs, w_r_hs;
  logic                      w_last_beat;
  logic [ADDR_WIDTH-1:0]     w_req_addr;
  logic [ID_WIDTH-1:0]       w_req_id;
  logic [7:0]                w_req_len;
  logic [1:0]                w_req_burst;
  logic [1:0]                w_req_resp;
  logic                      w_sram_re;
  logic [DATA_WIDTH/8-1:0]   w_sram_we;
  logic [DATA_WIDTH-1:0]     w_sram_q;
  logic                      w_unused;

  assign w_unused = ^{s_axi_awsize, s_axi_arsize};

  // Write wins a tie unless it was the last channel granted.
  assign w_grant_wr = s_axi_awvalid && (!s_axi_arvalid || r_last_grant_rd);
  assign w_grant_rd = s_axi_arvalid && !w_grant_wr;

  assign w_aw_hs = (r_state == ST_IDLE) && w_grant_wr;
  assign w_ar_hs = (r_state == ST_IDLE) && w_grant_rd;
  assign w_w_hs  = (r_state == ST_WR_DATA) && s_axi_wvalid;
  assign w_r_hs  = (r_state == ST_RD_DATA) && s_axi_rready;
  assign w_last_beat = (r_beat == r_len);

  // Request fields of whichever channel is being granted this cycle.
  assign w_req_addr  = w_grant_wr ? s_axi_awaddr  : s_axi_araddr;
  assign w_req_id    = w_grant_wr ? s_axi_awid    : s_axi_arid;
  assign w_req_len   = w_grant_wr ? s_axi_awlen   : s_axi_arlen;
  assign w_req_burst = w_grant_wr ? s_axi_awburst : s_axi_arburst;

  always_comb begin
    w_req_resp = RESP_OKAY;
    if (|(w_req_addr >> (LSB + MEM_DEPTH_LOG2))) begin
      w_req_resp = RESP_DECERR;
    end else if ((w_req_burst != BURST_FIXED) && (w_req_burst != BURST_INCR)) begin
      w_req_resp = RESP_SLVERR;
    end
  end

  // Once an error is latched the remaining beats are accepted but dropped.
  assign w_sram_we = (w_w_hs && (r_resp == RESP_OKAY)) ? s_axi_wstrb : '0;

  assign s_axi_bid = r_id;
  assign s_axi_rid = r_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    s_axi_awready = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = RESP_OKAY;
    s_axi_rvalid  = 1'b0;
    s_axi_rresp   = RESP_OKAY;
    s_axi_rlast   = 1'b0;
    s_axi_rdata   = '0;
    w_sram_re     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        s_axi_awready = w_grant_wr;
        s_axi_arready = w_grant_rd;
        if (w_grant_wr) begin
          w_next_state = ST_WR_DATA;
        end else if (w_grant_rd) begin
          w_next_state = ST_RD_FETCH;
        end
      end
      ST_WR_DATA: begin
        s_axi_wready = 1'b1;
        // Beat count, not wlast, ends the burst.
        if (s_axi_wvalid && w_last_beat) begin
          w_next_state = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bresp  = r_resp;
        if (s_axi_bready) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RD_FETCH: begin
        w_sram_re    = 1'b1;
        w_next_state = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        s_axi_rvalid = 1'b1;
        s_axi_rresp  = r_resp;
        s_axi_rlast  = w_last_beat;
        s_axi_rdata  = (r_resp == RESP_OKAY) ? w_sram_q : '0;
        if (s_axi_rready) begin
          w_next_state = w_last_beat ? ST_IDLE : ST_RD_FETCH;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant_rd <= 1'b1;
      r_id            <= '0;
      r_idx           <= '0;
      r_len           <= '0;
      r_beat          <= '0;
      r_fixed         <= 1'b0;
      r_resp          <= RESP_OKAY;
    end else if (w_aw_hs || w_ar_hs) begin
      r_last_grant_rd <= w_ar_hs;
      r_id            <= w_req_id;
      r_idx           <= w_req_addr[LSB +: MEM_DEPTH_LOG2];
      r_len           <= w_req_len;
      r_beat          <= '0;
      r_fixed         <= (w_req_burst == BURST_FIXED);
      r_resp          <= w_req_resp;
    end else if (w_w_hs || w_r_hs) begin
      // A misplaced wlast is a slave error, but never overrides DECERR.
      if (w_w_hs && (s_axi_wlast != w_last_beat) && (r_resp == RESP_OKAY)) begin
        r_resp <= RESP_SLVERR;
      end
      if (!w_last_beat) begin
        r_beat <= r_beat + 8'd1;
        if (!r_fixed) begin
          r_idx <= r_idx + MEM_DEPTH_LOG2'(1);
        end
      end
    end
  end

  vortex_axi_mem_sram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (MEM_DEPTH_LOG2)
  ) u_sram (
    .clk     (clk),
    .i_re    (w_sram_re),
    .i_we    (w_sram_we),
    .i_addr  (r_idx),
    .i_wdata (s_axi_wdata),
    .o_rdata (w_sram_q)
  );

endmodule

// File: tb/tb_vortex_axi_mem_slave.sv
// tb/tb_vortex_axi_mem_slave.sv - directed self-checking bench for vortex_axi_mem_slave
module tb_vortex_axi_mem_slave;
  import vortex_axi_mem_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_axi_awvalid = 1'b0, s_axi_awready;
  logic [63:0]  s_axi_awaddr = '0;
  logic [31:0]  s_axi_awid = '0;
  logic [7:0]   s_axi_awlen = '0;
  logic [2:0]   s_axi_awsize = 3'd6;
  logic [1:0]   s_axi_awburst = 2'd1;
  logic         s_axi_wvalid = 1'b0, s_axi_wready;
  logic [511:0] s_axi_wdata = '0;
  logic [63:0]  s_axi_wstrb = '0;
  logic         s_axi_wlast = 1'b0;
  logic         s_axi_bvalid, s_axi_bready = 1'b0;
  logic [31:0]  s_axi_bid;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_arvalid = 1'b0, s_axi_arready;
  logic [63:0]  s_axi_araddr = '0;
  logic [31:0]  s_axi_arid = '0;
  logic [7:0]   s_axi_arlen = '0;
  logic [2:0]   s_axi_arsize = 3'd6;
  logic [1:0]   s_axi_arburst = 2'd1;
  logic         s_axi_rvalid, s_axi_rready = 1'b0;
  logic [511:0] s_axi_rdata;
  logic         s_axi_rlast;
  logic [31:0]  s_axi_rid;
  logic [1:0]   s_axi_rresp;

  int n_cmp = 0;
  int n_err = 0;

  logic [511:0] wr_data [0:3];
  logic [511:0] rd_data [0:3];
  logic [1:0]   rd_resp [0:3];
  logic         rd_last [0:3];
  logic [31:0]  rd_id   [0:3];
  int           rd_lat  [0:3];
  logic [1:0]   b_resp;
  logic [31:0]  b_id;
  int           w_lat, b_lat;
  logic [511:0] pat_x;

  vortex_axi_mem_slave dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bid(s_axi_bid),
    .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rlast(s_axi_rlast), .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_awready"}, s_axi_awready, 1'b0);
    check({tag, "_arready"}, s_axi_arready, 1'b0);
    check({tag, "_wready"},  s_axi_wready,  1'b0);
    check({tag, "_bvalid"},  s_axi_bvalid,  1'b0);
    check({tag, "_rvalid"},  s_axi_rvalid,  1'b0);
    check({tag, "_rlast"},   s_axi_rlast,   1'b0);
    check({tag, "_bresp"},   s_axi_bresp,   2'd0);
    check({tag, "_rresp"},   s_axi_rresp,   2'd0);
    check({tag, "_bid"},     s_axi_bid,     32'd0);
    check({tag, "_rid"},     s_axi_rid,     32'd0);
    check({tag, "_rdata"},   s_axi_rdata,   512'd0);
  endtask

  task automatic write_burst(input logic [63:0] addr, input logic [31:0] id, input logic [7:0] len,
                             input logic [1:0] burst, input logic [63:0] strb, input int early_last);
    int cnt;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b1; s_axi_awaddr = addr; s_axi_awid = id;
    s_axi_awlen = len; s_axi_awburst = burst;
    cnt = 0; @(negedge clk);
    while (!s_axi_awready && cnt < 50) begin @(negedge clk); cnt++; end
    check("aw_grant", s_axi_awready, 1'b1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = wr_data[b]; s_axi_wstrb = strb;
      s_axi_wlast = (b == int'(len)) || (b == early_last);
      cnt = 0; @(negedge clk);
      while (!s_axi_wready && cnt < 50) begin @(negedge clk); cnt++; end
      if (b == 0) w_lat = cnt;
      check("w_ready", s_axi_wready, 1'b1);
      @(posedge clk); #1;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
    cnt = 0; @(negedge clk);
    while (!s_axi_bvalid && cnt < 50) begin @(negedge clk); cnt++; end
    b_lat = cnt;
    check("b_valid", s_axi_bvalid, 1'b1);
    b_resp = s_axi_bresp; b_id = s_axi_bid;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic read_burst(input logic [63:0] addr, input logic [31:0] id, input logic [7:0] len,
                            input logic [1:0] burst);
    int cnt;
    @(posedge clk); #1;
    s_axi_arvalid = 1'b1; s_axi_araddr = addr; s_axi_arid = id;
    s_axi_arlen = len; s_axi_arburst = burst;
    cnt = 0; @(negedge clk);
    while (!s_axi_arready && cnt < 50) begin @(negedge clk); cnt++; end
    check("ar_grant", s_axi_arready, 1'b1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      cnt = 1; @(negedge clk);
      while (!s_axi_rvalid && cnt < 50) begin @(negedge clk); cnt++; end
      check("r_valid", s_axi_rvalid, 1'b1);
      rd_lat[b] = cnt; rd_data[b] = s_axi_rdata; rd_resp[b] = s_axi_rresp;
      rd_last[b] = s_axi_rlast; rd_id[b] = s_axi_rid;
      @(posedge clk); #1;
    end
    s_axi_rready = 1'b0;
  endtask

  initial begin
    pat_x = {8{64'h0123_4567_89AB_CDEF}};
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst_n = 1'b1;

    // Tie from reset: write first, then read.
    @(posedge clk); #1;
    s_axi_awvalid = 1'b1; s_axi_awaddr = 64'h400; s_axi_awid = 32'd1; s_axi_awlen = 8'd0; s_axi_awburst = BURST_INCR;
    s_axi_arvalid = 1'b1; s_axi_araddr = 64'h400; s_axi_arid = 32'd2; s_axi_arlen = 8'd0; s_axi_arburst = BURST_INCR;
    @(negedge clk);
    check("arb1_awready", s_axi_awready, 1'b1);
    check("arb1_arready", s_axi_arready, 1'b0);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b1; s_axi_wdata = pat_x; s_axi_wstrb = '1; s_axi_wlast = 1'b1;
    @(negedge clk);
    check("arb_wready", s_axi_wready, 1'b1);
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
    @(negedge clk);
    check("arb_bvalid", s_axi_bvalid, 1'b1);
    check("arb_bid", s_axi_bid, 32'd1);
    @(posedge clk); #1;
    s_axi_bready = 1'b0; s_axi_awvalid = 1'b1; s_axi_awid = 32'd3;
    @(negedge clk);
    check("arb2_arready", s_axi_arready, 1'b1);
    check("arb2_awready", s_axi_awready, 1'b0);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_rready = 1'b1;
    @(negedge clk);
    check("arb_fetch_rvalid", s_axi_rvalid, 1'b0);
    @(negedge clk);
    check("arb_rvalid", s_axi_rvalid, 1'b1);
    check("arb_rdata", s_axi_rdata, pat_x);
    check("arb_rid", s_axi_rid, 32'd2);
    check("arb_rlast", s_axi_rlast, 1'b1);
    @(posedge clk); #1;
    s_axi_rready = 1'b0;

    // INCR write then read of 0x40, 4 beats.
    for (int k = 0; k < 4; k++) wr_data[k] = {16{32'hA000_0000 + k}};
    write_burst(64'h40, 32'h11, 8'd3, BURST_INCR, '1, -1);
    check("incr_w_lat", w_lat, 0);
    check("incr_b_lat", b_lat, 0);
    check("incr_bresp", b_resp, RESP_OKAY);
    check("incr_bid", b_id, 32'h11);
    read_burst(64'h40, 32'h22, 8'd3, BURST_INCR);
    for (int k = 0; k < 4; k++) begin
      check("incr_rdata", rd_data[k], {16{32'hA000_0000 + k}});
      check("incr_rlast", rd_last[k], k == 3);
      check("incr_rresp", rd_resp[k], RESP_OKAY);
      check("incr_rlat", rd_lat[k], 2);
    end
    check("incr_rid", rd_id[0], 32'h22);

    // Partial strobe.
    wr_data[0] = '1;
    write_burst(64'h200, 32'h5, 8'd0, BURST_INCR, '1, -1);
    wr_data[0] = '0;
    write_burst(64'h200, 32'h5, 8'd0, BURST_INCR, 64'h1, -1);
    read_burst(64'h200, 32'h6, 8'd0, BURST_INCR);
    check("strb_rdata", rd_data[0], {{504{1'b1}}, 8'h00});

    // DECERR write leaves index 1 untouched; DECERR read returns zeros.
    wr_data[0] = {16{32'hDEAD_BEEF}};
    write_burst(64'h1_0040, 32'h7, 8'd0, BURST_INCR, '1, -1);
    check("dec_bresp", b_resp, RESP_DECERR);
    read_burst(64'h40, 32'h8, 8'd0, BURST_INCR);
    check("dec_mem_kept", rd_data[0], {16{32'hA000_0000}});
    read_burst(64'h1_0040, 32'h9, 8'd2, BURST_INCR);
    for (int k = 0; k < 3; k++) begin
      check("dec_rdata", rd_data[k], 512'd0);
      check("dec_rresp", rd_resp[k], RESP_DECERR);
      check("dec_rlast", rd_last[k], k == 2);
    end

    // WRAP read gives SLVERR on every beat.
    read_burst(64'h40, 32'hA, 8'd1, BURST_WRAP);
    for (int k = 0; k < 2; k++) begin
      check("wrap_rresp", rd_resp[k], RESP_SLVERR);
      check("wrap_rdata", rd_data[k], 512'd0);
    end
    check("wrap_rlast", rd_last[1], 1'b1);

    // Early wlast still takes 4 beats and ends in SLVERR.
    for (int k = 0; k < 4; k++) wr_data[k] = {16{32'hB000_0000 + k}};
    write_burst(64'h800, 32'hB, 8'd3, BURST_INCR, '1, 0);
    check("early_bresp", b_resp, RESP_SLVERR);

    // INCR starting at the last index wraps to index 0.
    wr_data[0] = {16{32'hC000_0000}};
    wr_data[1] = {16{32'hC000_0001}};
    write_burst(64'hFFC0, 32'hC, 8'd1, BURST_INCR, '1, -1);
    read_burst(64'h0, 32'hC, 8'd0, BURST_INCR);
    check("idxwrap_beat1", rd_data[0], {16{32'hC000_0001}});
    read_burst(64'hFFC0, 32'hC, 8'd1, BURST_INCR);
    check("idxwrap_rd0", rd_data[0], {16{32'hC000_0000}});
    check("idxwrap_rd1", rd_data[1], {16{32'hC000_0001}});

    // Reset in the middle of a write burst.
    for (int k = 0; k < 4; k++) wr_data[k] = {16{32'hD000_0000 + k}};
    write_burst(64'hC00, 32'hD, 8'd3, BURST_INCR, '1, -1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b1; s_axi_awaddr = 64'hC00; s_axi_awid = 32'hE; s_axi_awlen = 8'd3; s_axi_awburst = BURST_INCR;
    @(negedge clk);
    check("rst_aw", s_axi_awready, 1'b1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = {16{32'hE000_0000 + b}}; s_axi_wstrb = '1; s_axi_wlast = 1'b0;
      @(negedge clk);
      check("rst_wready", s_axi_wready, 1'b1);
      @(posedge clk); #1;
    end
    s_axi_wdata = {16{32'hE000_0002}};
    #1 rst_n = 1'b0;
    #1;
    check_quiet("midrst");
    repeat (2) @(posedge clk);
    s_axi_wdata = {16{32'hE000_0003}};
    @(negedge clk);
    check_quiet("midrst_hold");
    s_axi_wvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_bvalid", s_axi_bvalid, 1'b0);
    end
    read_burst(64'hC00, 32'hF, 8'd3, BURST_INCR);
    check("rst_beat0", rd_data[0], {16{32'hE000_0000}});
    check("rst_beat1", rd_data[1], {16{32'hE000_0001}});
    check("rst_beat2", rd_data[2], {16{32'hD000_0002}});
    check("rst_beat3", rd_data[3], {16{32'hD000_0003}});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
